mips_multicycle_control: RTL and testbench

Moore-style control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It generates the write enables and mux selects for the PC register, instruction register, memory, register file and ALU. The PC register's `enable` input is driven directly by this block's `pc_en` output.

---
 rtl/mips_multicycle_control_pkg.sv | 67 ++++++
 rtl/mips_multicycle_control_if.sv | 33 +++
 rtl/mips_control_out_decode.sv | 63 ++++++
 rtl/mips_multicycle_control.sv | 81 ++++++++
 tb/tb_mips_multicycle_control.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, state
// encoding, mux-select encodings and the decoded control word.
package mips_multicycle_control_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  // Supported instruction opcodes (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Branch is split into an eq and a ne state so the branch flavour is
  // carried by the state itself and opcode need not be read in BRANCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALUWB     = 4'd7,
    S_ADDIWB    = 4'd8,
    S_BRANCH_EQ = 4'd9,
    S_BRANCH_NE = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  // Control word decoded purely from the current state
  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath signal bundle.
//   master: control FSM (drives enables/selects, reads opcode/zero)
//   slave : datapath    (drives opcode/zero, reads enables/selects)
interface mips_multicycle_control_if;
  import mips_multicycle_control_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                pc_en;
  logic                i_or_d;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic                illegal_op;

  modport master (
    input  opcode, zero,
    output pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );

  modport slave (
    output opcode, zero,
    input  pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );
endinterface

// File: rtl/mips_control_out_decode.sv
// Combinational state -> control word decode (Moore outputs).
//   state_i : current FSM state
//   ctrl_o  : enables, selects and internal branch/pc_write qualifiers
module mips_control_out_decode
  import mips_multicycle_control_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      // Branch target precomputed into ALUOut while the opcode is decoded
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:  ctrl_o.i_or_d = 1'b1;
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_BRANCH_EQ: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch_eq = 1'b1;
      end
      S_BRANCH_NE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch_ne = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath enables and mux selects.
//   clk   : rising-edge clock
//   reset : async active-high, forces FETCH and masks all enables/strobes
//   bus   : control bundle (master side), see mips_multicycle_control_if
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  state_e     state_q;
  state_e     state_d;
  ctrl_word_t ctrl;
  logic       illegal_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR
  always_comb begin
    state_d   = S_FETCH;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = S_EXECUTE;
          OP_BEQ:                state_d = S_BRANCH_EQ;
          OP_BNE:                state_d = S_BRANCH_NE;
          OP_J:                  state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        case (bus.opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          OP_ADDI: state_d = S_ADDIWB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mips_control_out_decode u_out_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Enables are masked by reset so an aborted instruction writes nothing
  // in the reset cycle itself; selects keep their FETCH values.
  assign bus.pc_en      = ~reset & (ctrl.pc_write
                                  | (ctrl.branch_eq &  bus.zero)
                                  | (ctrl.branch_ne & ~bus.zero));
  assign bus.mem_write  = ~reset & ctrl.mem_write;
  assign bus.ir_write   = ~reset & ctrl.ir_write;
  assign bus.reg_write  = ~reset & ctrl.reg_write;
  assign bus.illegal_op = ~reset & illegal_c;

  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. Expected outputs come
// from a per-instruction cycle model (opcode, cycle index within the
// instruction, zero flag) built from the instruction timing rules.
module tb_mips_multicycle_control;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   pc_en_seen;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    return op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
           op == T_BNE || op == T_ADDI || op == T_J;
  endfunction

  function automatic int cpi(input logic [5:0] op);
    case (op)
      T_LW:                 return 5;
      T_SW, T_R, T_ADDI:    return 4;
      T_BEQ, T_BNE, T_J:    return 3;
      default:              return 2;
    endcase
  endfunction

  // Packing: {pc_en,i_or_d,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
  //           alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],illegal_op}
  function automatic logic [14:0] observed();
    return {bus.pc_en, bus.i_or_d, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.illegal_op};
  endfunction

  function automatic logic [14:0] reset_word();
    return {8'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  endfunction

  // Expected outputs for cycle k of instruction op
  function automatic logic [14:0] model(input logic [5:0] op, input int k,
                                        input logic z);
    logic pe, iod, mw, irw, rd, m2r, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    {pe, iod, mw, irw, rd, m2r, rw, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    if (k == 0) begin
      pe = 1'b1; irw = 1'b1; sb = 2'b01;
    end else if (k == 1) begin
      sb = 2'b11; ill = !is_legal(op);
    end else if (k == 2) begin
      case (op)
        T_LW, T_SW, T_ADDI: begin sa = 1'b1; sb = 2'b10; end
        T_R:   begin sa = 1'b1; ao = 2'b10; end
        T_BEQ: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; end
        T_BNE: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = ~z; end
        T_J:   begin pe = 1'b1; ps = 2'b10; end
        default: ;
      endcase
    end else if (k == 3) begin
      case (op)
        T_LW:   iod = 1'b1;
        T_SW:   begin iod = 1'b1; mw = 1'b1; end
        T_R:    begin rw = 1'b1; rd = 1'b1; end
        T_ADDI: rw = 1'b1;
        default: ;
      endcase
    end else if (k == 4 && op == T_LW) begin
      rw = 1'b1; m2r = 1'b1;
    end
    return {pe, iod, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill};
  endfunction

  // Runs one whole instruction starting in FETCH. zmode: 0 random zero,
  // 1 force zero=1 in cycle 3, 2 force zero=0 in cycle 3. Opcode is only
  // held stable in cycles 2-3; elsewhere it is scrambled.
  task automatic run_instr(input logic [5:0] op, input int zmode);
    logic [14:0] exp_v;
    logic [14:0] got_v;
    for (int k = 0; k < cpi(op); k++) begin
      bus.opcode = (k == 1 || k == 2) ? op : 6'($urandom);
      if (k == 2 && zmode == 1)      bus.zero = 1'b1;
      else if (k == 2 && zmode == 2) bus.zero = 1'b0;
      else                           bus.zero = 1'($urandom);
      #1;
      exp_v = model(op, k, bus.zero);
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL instr op=%b cycle=%0d: got %b expected %b",
                 op, k + 1, got_v, exp_v);
      end
      if (bus.pc_en === 1'b1) pc_en_seen++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [14:0] got_v;
    reset = 1'b1;
    bus.opcode = 6'($urandom);
    bus.zero = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.zero = 1'($urandom);
      #1;
      got_v = observed();
      n_checks++;
      if (got_v !== reset_word()) begin
        n_fail++;
        $display("FAIL reset_hold cycle=%0d: got %b expected %b",
                 c, got_v, reset_word());
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    got_v = observed();
    n_checks++;
    if (got_v !== model(T_R, 0, bus.zero)) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b",
               got_v, model(T_R, 0, bus.zero));
    end
  endtask

  task automatic test_lw();
    run_instr(T_LW, 0);
  endtask

  task automatic test_branch();
    run_instr(T_BEQ, 1);
    run_instr(T_BEQ, 2);
    run_instr(T_BNE, 2);
    run_instr(T_BNE, 1);
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    run_instr(6'b111111, 0);
    for (int i = 0; i < 4; i++) begin
      op = 6'($urandom);
      while (is_legal(op)) op = 6'($urandom);
      run_instr(op, 0);
    end
  endtask

  // Reset pulsed while sw sits in its memory-write cycle
  task automatic test_reset_mid();
    logic [14:0] got_v;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = (k == 1 || k == 2) ? T_SW : 6'($urandom);
      bus.zero = 1'($urandom);
      #1;
      if (k < 3) @(negedge clk);
    end
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_precheck: mem_write got %b expected 1",
               bus.mem_write);
    end
    reset = 1'b1;
    #1;
    got_v = observed();
    n_checks++;
    if (got_v !== reset_word()) begin
      n_fail++;
      $display("FAIL reset_mid_same_cycle: got %b expected %b",
               got_v, reset_word());
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    got_v = observed();
    n_checks++;
    if (got_v !== model(T_SW, 0, bus.zero)) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %b expected %b",
               got_v, model(T_SW, 0, bus.zero));
    end
  endtask

  task automatic test_back_to_back();
    pc_en_seen = 0;
    run_instr(T_R, 0);
    run_instr(T_SW, 0);
    run_instr(T_ADDI, 0);
    run_instr(T_J, 0);
    n_checks++;
    if (pc_en_seen !== 5) begin
      n_fail++;
      $display("FAIL back_to_back_pc_en_count: got %0d expected 5",
               pc_en_seen);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] op;
    int sel;
    ops = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J};
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      op = (sel == 7) ? 6'($urandom) : ops[sel];
      run_instr(op, 0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    pc_en_seen = 0;
    reset      = 1'b1;
    bus.opcode = '0;
    bus.zero   = 1'b0;
    test_reset();
    test_lw();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
